// File: rtl/sampstream_pkg.sv
// Shared definitions for the sample-stream arbiter: FSM states, header marker
// and register map.
package sampstream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [3:0] HDR_MARKER   = 4'hA;

    localparam logic [2:0] REG_EN_LO    = 3'd0;
    localparam logic [2:0] REG_EN_HI    = 3'd1;
    localparam logic [2:0] REG_MAXBURST = 3'd2;
    localparam logic [2:0] REG_STATUS   = 3'd3;
    localparam logic [2:0] REG_BURSTS   = 3'd4;

endpackage

// File: rtl/sampstream_rr_pick.sv
// Combinational round-robin picker: first eligible channel after last_grant,
// searching modulo NUM_CH.
module sampstream_rr_pick #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] eligible,
    input  logic [CH_W-1:0]   last_grant,
    output logic              any,
    output logic [CH_W-1:0]   pick
);

    int unsigned idx;

    always_comb begin
        any  = 1'b0;
        pick = last_grant;
        idx  = 0;
        // k runs 1..NUM_CH so last_grant itself is tried last.
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last_grant) + k) % NUM_CH;
            if (!any && eligible[idx]) begin
                any  = 1'b1;
                pick = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sampstream_arbiter.sv
// Round-robin merge of NUM_CH sampleq streams into one host stream of
// header-prefixed, fixed-length bursts, with a small Wishbone register bank.
module sampstream_arbiter
    import sampstream_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH*32-1:0] in_data,
    input  logic [NUM_CH*8-1:0]  in_count,
    input  logic [NUM_CH-1:0]    in_avail,
    output logic [NUM_CH-1:0]    in_pull,
    output logic [31:0]          out_data,
    output logic                 out_avail,
    input  logic                 out_pull,
    input  logic                 wb_stb_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_we_i,
    input  logic [15:0]          wb_adr_i,
    input  logic [7:0]           wb_dat_i,
    output logic [7:0]           wb_dat_o,
    output logic                 wb_ack_o
);

    state_t            state;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   last_grant;
    logic [7:0]        remaining;
    logic [7:0]        max_burst;
    logic [NUM_CH-1:0] enable_mask;
    logic [31:0]       burst_counter;

    logic [NUM_CH-1:0] eligible;
    logic              any;
    logic [CH_W-1:0]   pick;
    logic [7:0]        pick_count;
    logic              grant_avail;
    logic [31:0]       grant_data;
    logic [15:0]       enable_full;
    logic              wr;
    logic              unused_adr;

    assign wr         = wb_cyc_i && wb_stb_i && wb_we_i;
    assign wb_ack_o   = 1'b1;
    assign unused_adr = ^wb_adr_i[15:3];

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            eligible[i] = enable_mask[i] && in_avail[i] &&
                          (in_count[8*i +: 8] != 8'd0) && (max_burst != 8'd0);
        end
        pick_count  = in_count[8*int'(pick) +: 8];
        grant_avail = in_avail[grant];
        grant_data  = in_data[32*int'(grant) +: 32];
    end

    sampstream_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_pick (
        .eligible   (eligible),
        .last_grant (last_grant),
        .any        (any),
        .pick       (pick)
    );

    // Outputs are decoded from registered state; rst masks the handshake so the
    // sampleq sees no pull on the edge where reset is taken.
    always_comb begin
        out_avail = 1'b0;
        out_data  = '0;
        in_pull   = '0;
        case (state)
            HDR: begin
                out_avail = 1'b1;
                out_data  = {HDR_MARKER, 4'(grant), 16'h0000, remaining};
            end
            DATA: begin
                out_avail      = grant_avail;
                out_data       = grant_data;
                in_pull[grant] = out_pull && grant_avail;
            end
            default: ;
        endcase
        if (rst) begin
            out_avail = 1'b0;
            in_pull   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            grant         <= '0;
            last_grant    <= CH_W'(NUM_CH - 1);
            remaining     <= '0;
            max_burst     <= 8'd255;
            enable_mask   <= '1;
            burst_counter <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        grant     <= pick;
                        remaining <= (pick_count < max_burst) ? pick_count : max_burst;
                        state     <= HDR;
                    end
                end
                HDR: begin
                    if (out_pull) state <= DATA;
                end
                DATA: begin
                    if (grant_avail && out_pull) begin
                        remaining <= remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            last_grant    <= grant;
                            burst_counter <= burst_counter + 32'd1;
                            state         <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (wr) begin
                case (wb_adr_i[2:0])
                    REG_EN_LO: begin
                        for (int unsigned b = 0; b < 8; b++)
                            if (b < NUM_CH) enable_mask[b] <= wb_dat_i[b];
                    end
                    REG_EN_HI: begin
                        for (int unsigned b = 0; b < 8; b++)
                            if (b + 8 < NUM_CH) enable_mask[b+8] <= wb_dat_i[b];
                    end
                    REG_MAXBURST: max_burst <= wb_dat_i;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        enable_full              = '0;
        enable_full[NUM_CH-1:0]  = enable_mask;
        case (wb_adr_i[2:0])
            REG_EN_LO:           wb_dat_o = enable_full[7:0];
            REG_EN_HI:           wb_dat_o = enable_full[15:8];
            REG_MAXBURST:        wb_dat_o = max_burst;
            REG_STATUS:          wb_dat_o = {state, 2'b00, 4'(grant)};
            REG_BURSTS:          wb_dat_o = burst_counter[7:0];
            REG_BURSTS + 3'd1:   wb_dat_o = burst_counter[15:8];
            REG_BURSTS + 3'd2:   wb_dat_o = burst_counter[23:16];
            default:             wb_dat_o = burst_counter[31:24];
        endcase
    end

endmodule

// File: tb/tb_sampstream_arbiter.sv
// Randomized bench: emulated sampleq sources feed the arbiter; a burst-level
// reference model predicts every output word, pull and register read.
module tb_sampstream_arbiter;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int CYCLES = 4000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_CH*32-1:0] in_data;
    logic [NUM_CH*8-1:0]  in_count;
    logic [NUM_CH-1:0]    in_avail;
    logic [NUM_CH-1:0]    in_pull;
    logic [31:0]          out_data;
    logic                 out_avail;
    logic                 out_pull;
    logic                 wb_stb_i, wb_cyc_i, wb_we_i;
    logic [15:0]          wb_adr_i;
    logic [7:0]           wb_dat_i;
    logic [7:0]           wb_dat_o;
    logic                 wb_ack_o;

    always #5 clk = ~clk;

    sampstream_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_count  (in_count),
        .in_avail  (in_avail),
        .in_pull   (in_pull),
        .out_data  (out_data),
        .out_avail (out_avail),
        .out_pull  (out_pull),
        .wb_stb_i  (wb_stb_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_we_i   (wb_we_i),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Emulated sampleq contents and the reference model state.
    logic [31:0]       src [NUM_CH][$];
    logic [31:0]       burst_q[$];
    bit                busy, hdr_pend;
    logic [31:0]       hdr_word;
    int                m_grant, m_last;
    logic [15:0]       m_en;
    logic [7:0]        m_maxb;
    logic [31:0]       m_bursts;
    logic [NUM_CH-1:0] stall;
    int                seqn = 0;

    task automatic model_reset();
        burst_q.delete();
        busy     = 1'b0;
        hdr_pend = 1'b0;
        m_grant  = 0;
        m_last   = NUM_CH - 1;
        m_en     = 16'((1 << NUM_CH) - 1);
        m_maxb   = 8'd255;
        m_bursts = '0;
    endtask

    task automatic drive_src();
        for (int i = 0; i < NUM_CH; i++) begin
            in_data[32*i +: 32] = (src[i].size() > 0) ? src[i][0] : 32'h0;
            in_count[8*i +: 8]  = (src[i].size() > 255) ? 8'd255 : 8'(src[i].size());
            in_avail[i]         = (src[i].size() > 0) && !stall[i];
        end
    endtask

    function automatic logic [7:0] exp_read(input logic [2:0] adr);
        logic [1:0] st;
        st = !busy ? 2'd0 : (hdr_pend ? 2'd1 : 2'd2);
        case (adr)
            3'd0:    return m_en[7:0];
            3'd1:    return m_en[15:8];
            3'd2:    return m_maxb;
            3'd3:    return {st, 2'b00, 4'(m_grant)};
            3'd4:    return m_bursts[7:0];
            3'd5:    return m_bursts[15:8];
            3'd6:    return m_bursts[23:16];
            default: return m_bursts[31:24];
        endcase
    endfunction

    // One cycle of the reference: compare, then advance to the next-cycle view.
    task automatic model_step();
        int g, n;
        logic avail_g;
        logic [NUM_CH-1:0] exp_pull;
        check("rd_data", 32'(wb_dat_o), 32'(exp_read(wb_adr_i[2:0])));
        check("ack", 32'(wb_ack_o), 32'd1);
        if (rst) begin
            check("pull_in_rst", 32'(in_pull), 32'd0);
            model_reset();
            return;
        end
        if (!busy) begin
            check("idle_avail", 32'(out_avail), 32'd0);
            check("idle_pull", 32'(in_pull), 32'd0);
            g = -1;
            for (int k = 1; k <= NUM_CH; k++) begin
                int c;
                c = (m_last + k) % NUM_CH;
                if (g < 0 && m_en[c] && in_avail[c] && in_count[8*c +: 8] != 8'd0 && m_maxb != 8'd0)
                    g = c;
            end
            if (g >= 0) begin
                n = (int'(in_count[8*g +: 8]) < int'(m_maxb)) ? int'(in_count[8*g +: 8]) : int'(m_maxb);
                m_grant  = g;
                hdr_word = {4'hA, 4'(g), 16'h0000, 8'(n)};
                for (int j = 0; j < n; j++) burst_q.push_back(src[g][j]);
                busy     = 1'b1;
                hdr_pend = 1'b1;
            end
        end else if (hdr_pend) begin
            check("hdr_avail", 32'(out_avail), 32'd1);
            check("hdr_data", out_data, hdr_word);
            check("hdr_pull", 32'(in_pull), 32'd0);
            if (out_pull) hdr_pend = 1'b0;
        end else begin
            avail_g  = in_avail[m_grant];
            exp_pull = '0;
            exp_pull[m_grant] = avail_g && out_pull;
            check("data_avail", 32'(out_avail), 32'(avail_g));
            check("data_pull", 32'(in_pull), 32'(exp_pull));
            if (avail_g) check("data_word", out_data, burst_q[0]);
            if (avail_g && out_pull) begin
                void'(burst_q.pop_front());
                void'(src[m_grant].pop_front());
                if (burst_q.size() == 0) begin
                    busy     = 1'b0;
                    m_last   = m_grant;
                    m_bursts = m_bursts + 32'd1;
                end
            end
        end
        if (wb_cyc_i && wb_stb_i && wb_we_i) begin
            case (wb_adr_i[2:0])
                3'd0: m_en[7:0]  = wb_dat_i;
                3'd1: m_en[15:8] = wb_dat_i;
                3'd2: m_maxb     = wb_dat_i;
                default: ;
            endcase
            m_en = m_en & 16'((1 << NUM_CH) - 1);
        end
    endtask

    initial begin
        rst      = 1'b1;
        out_pull = 1'b0;
        stall    = '0;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_adr_i = '0;
        wb_dat_i = '0;
        model_reset();
        drive_src();
        repeat (2) @(posedge clk);

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clk);
            rst = (cyc > 100) && ($urandom % 300 == 0);
            for (int i = 0; i < NUM_CH; i++) begin
                if (src[i].size() < 300 && $urandom % 8 == 0) begin
                    int cnt;
                    cnt = $urandom_range(1, 40);
                    for (int j = 0; j < cnt; j++) begin
                        src[i].push_back({8'(i), 24'(seqn)});
                        seqn++;
                    end
                end
                stall[i] = ((cyc / 700) % 2 == 1) && ($urandom % 3 == 0);
            end
            out_pull = ($urandom % 4 != 0);
            wb_cyc_i = 1'b1;
            wb_stb_i = 1'b1;
            wb_we_i  = ($urandom % 20 == 0);
            wb_adr_i = 16'($urandom);
            wb_dat_i = 8'($urandom);
            if (wb_adr_i[2:0] == 3'd2) begin
                case ($urandom % 4)
                    0: wb_dat_i = 8'd0;
                    1: wb_dat_i = 8'd255;
                    default: wb_dat_i = 8'($urandom_range(1, 12));
                endcase
            end
            drive_src();
            #1;
            model_step();
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
